alu_issue_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the ALU: captures decoded operands, resolves forwarding from the two downstream stages, and presents registered a, b, op and unsig to the ALU.
- Detects load-use hazards and stalls upstream.
- Uses a valid/ready handshake on both sides, supports pipeline flush, and keeps a saturating stall counter for performance debug.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_fwd_mux.sv | 29 ++
 rtl/alu_issue_stage.sv | 109 ++++++++++
 tb/tb_alu_issue_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and opcode legality.
package alu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;
  localparam int CNTW_DEF  = 16;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_XOR, ALU_SUB};
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Resolves one source operand from EX/MEM, MEM/WB or the register file; r0 reads as zero.
// Purely combinational; EX wins over WB, and an in-flight load never forwards.
module alu_fwd_mux import alu_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] src,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             ex_wen,
  input  logic             ex_load,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             wb_wen,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  operand
);

  always_comb begin
    operand = rf_data;
    if (src == '0)
      operand = '0;
    else if (ex_wen && !ex_load && ex_rd == src)
      operand = ex_data;
    else if (wb_wen && wb_rd == src)
      operand = wb_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: forwarding, load-use stall, flush, saturating stall counter.
// One-cycle latency; in_ready drops on load-use hazard or when the held op is not consumed.
module alu_issue_stage import alu_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [XLEN-1:0]  in_rs_data,
  input  logic [XLEN-1:0]  in_rt_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_op,
  input  logic             in_unsig,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_flush,
  input  logic             ex_wen,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             ex_load,
  input  logic             wb_wen,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [2:0]       op,
  output logic             unsig,
  output logic [RADDR-1:0] out_rd,
  output logic             out_illegal,
  output logic [CNTW-1:0]  stall_count
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic            src_a_used;
  logic            src_b_used;
  logic            hazard;
  logic            space;
  logic            accept;
  logic            stall_inc;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign src_a_used = (in_rs != '0);
  assign src_b_used = !in_use_imm && (in_rt != '0);

  // Load result is not available until after MEM, so a dependent op must wait a cycle.
  assign hazard = in_valid && ex_load && ex_wen && (ex_rd != '0) &&
                  ((src_a_used && ex_rd == in_rs) || (src_b_used && ex_rd == in_rt));

  assign space     = !out_valid || out_ready;
  assign in_ready  = in_flush || (space && !hazard);
  assign accept    = in_valid && in_ready && !in_flush;
  assign stall_inc = hazard && space && !in_flush;

  alu_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_a (
    .src(in_rs), .rf_data(in_rs_data),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_a)
  );

  alu_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_b (
    .src(in_rt), .rf_data(in_rt_data),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_b)
  );

  // A flush clears only the valid bit; the data registers keep their last contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      a           <= '0;
      b           <= '0;
      op          <= ALU_AND;
      unsig       <= 1'b0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (in_flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      a           <= fwd_a;
      b           <= in_use_imm ? in_imm : fwd_b;
      op          <= in_op;
      unsig       <= in_unsig;
      out_rd      <= in_rd;
      out_illegal <= !is_legal_op(in_op);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall_inc && stall_count != '1)
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, multi-cycle sequences, random run vs a transaction model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd, ex_rd, wb_rd, out_rd;
  logic [31:0] in_rs_data, in_rt_data, in_imm, ex_data, wb_data, a, b;
  logic        in_use_imm, in_unsig, in_flush, ex_wen, ex_load, wb_wen;
  logic [2:0]  in_op, op;
  logic        out_valid, out_ready, unsig, out_illegal;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op), .in_unsig(in_unsig),
    .in_rd(in_rd), .in_flush(in_flush),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data), .ex_load(ex_load),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .op(op), .unsig(unsig), .out_rd(out_rd),
    .out_illegal(out_illegal), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        use_imm;
    logic [2:0]  op;
    logic        unsig;
    logic [4:0]  rd;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_load;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic [31:0] exp_a, exp_b;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        unsig;
    logic [4:0]  rd;
    logic        ill;
  } txn_t;

  vec_t vecs[13];
  txn_t held[$];
  int   m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_use_imm = 0; in_op = 0; in_unsig = 0; in_rd = 0; in_flush = 0;
    ex_wen = 0; ex_rd = 0; ex_data = 0; ex_load = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [31:0] rsd, input logic [2:0] opc, input logic [4:0] rd);
    in_valid = 1; in_rs = rs; in_rs_data = rsd; in_rt = 0; in_rt_data = 0;
    in_use_imm = 0; in_op = opc; in_unsig = 0; in_rd = rd; in_flush = 0;
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 0;
    if (ex_wen && !ex_load && ex_rd == r) return ex_data;
    if (wb_wen && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    logic [4:0] srcs[$];
    if (in_rs != 0) srcs.push_back(in_rs);
    if (!in_use_imm && in_rt != 0) srcs.push_back(in_rt);
    if (!(in_valid && ex_load && ex_wen && ex_rd != 0)) return 0;
    foreach (srcs[i]) if (srcs[i] == ex_rd) return 1;
    return 0;
  endfunction

  initial begin
    logic [31:0] sa, sb;
    logic [15:0] s0;

    // rs rt rs_data rt_data imm use_imm op unsig rd | ex_wen ex_rd ex_data ex_load | wb_wen wb_rd wb_data | ready a b ill
    vecs[0]  = '{5'd3, 5'd4, 32'h11, 32'h22, 32'h0, 1'b0, 3'b010, 1'b0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b0};
    vecs[1]  = '{5'd5, 5'd6, 32'h5555, 32'h66, 32'h0, 1'b0, 3'b000, 1'b1, 5'd11, 1'b1, 5'd5, 32'hAAAA0000, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b1, 32'hAAAA0000, 32'h66, 1'b0};
    vecs[2]  = '{5'd0, 5'd6, 32'hDEAD, 32'h66, 32'h0, 1'b0, 3'b001, 1'b0, 5'd12, 1'b1, 5'd5, 32'hAAAA0000, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b1, 32'h0, 32'h66, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 3'b010, 1'b0, 5'd13, 1'b1, 5'd0, 32'hFF, 1'b0, 1'b1, 5'd0, 32'hEE, 1'b1, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{5'd9, 5'd10, 32'h9, 32'hA, 32'h0, 1'b0, 3'b101, 1'b0, 5'd14, 1'b0, 5'd9, 32'hCCCC, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 32'h99, 32'hA, 1'b0};
    vecs[5]  = '{5'd7, 5'd4, 32'h7, 32'h4, 32'h0, 1'b0, 3'b010, 1'b0, 5'd15, 1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{5'd2, 5'd7, 32'h2, 32'h7, 32'hF00D, 1'b1, 3'b010, 1'b0, 5'd16, 1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h2, 32'hF00D, 1'b0};
    vecs[7]  = '{5'd3, 5'd7, 32'h3, 32'h77, 32'h0, 1'b0, 3'b110, 1'b1, 5'd17, 1'b0, 5'd7, 32'h123, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h3, 32'h77, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 3'b100, 1'b0, 5'd18, 1'b1, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0};
    vecs[9]  = '{5'd1, 5'd2, 32'hA1, 32'hB2, 32'h0, 1'b0, 3'b111, 1'b0, 5'd19, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA1, 32'hB2, 1'b1};
    vecs[10] = '{5'd1, 5'd2, 32'hA1, 32'hB2, 32'h0, 1'b0, 3'b011, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA1, 32'hB2, 1'b1};
    vecs[11] = '{5'd8, 5'd8, 32'h80, 32'h81, 32'h0, 1'b0, 3'b010, 1'b0, 5'd21, 1'b1, 5'd8, 32'h888, 1'b0, 1'b1, 5'd8, 32'h999, 1'b1, 32'h888, 32'h888, 1'b0};
    vecs[12] = '{5'd6, 5'd6, 32'h60, 32'h61, 32'h0, 1'b0, 3'b010, 1'b0, 5'd22, 1'b1, 5'd9, 32'hDEAD, 1'b1, 1'b1, 5'd6, 32'h777, 1'b1, 32'h777, 32'h777, 1'b0};

    // Reset state
    idle();
    reset = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_unsig", unsig, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    reset = 0;
    tick();

    // Directed vector table, downstream always ready
    foreach (vecs[i]) begin
      in_valid = 1; in_flush = 0; out_ready = 1;
      in_rs = vecs[i].rs; in_rt = vecs[i].rt; in_rs_data = vecs[i].rs_data; in_rt_data = vecs[i].rt_data;
      in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm; in_op = vecs[i].op; in_unsig = vecs[i].unsig;
      in_rd = vecs[i].rd;
      ex_wen = vecs[i].ex_wen; ex_rd = vecs[i].ex_rd; ex_data = vecs[i].ex_data; ex_load = vecs[i].ex_load;
      wb_wen = vecs[i].wb_wen; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ready);
      if (vecs[i].exp_ready) begin
        chk($sformatf("vec%0d_a", i), a, vecs[i].exp_a);
        chk($sformatf("vec%0d_b", i), b, vecs[i].exp_b);
        chk($sformatf("vec%0d_op", i), op, vecs[i].op);
        chk($sformatf("vec%0d_unsig", i), unsig, vecs[i].unsig);
        chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
        chk($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].exp_ill);
      end
    end

    // Load-use stall then WB forwarding on the retry
    idle();
    s0 = stall_count;
    drive_instr(5'd7, 32'h70, 3'b010, 5'd1);
    ex_wen = 1; ex_load = 1; ex_rd = 7;
    #1;
    chk("ldu_in_ready", in_ready, 0);
    tick();
    chk("ldu_stall_count", stall_count, s0 + 16'd1);
    chk("ldu_out_valid", out_valid, 0);
    ex_wen = 0; ex_load = 0; wb_wen = 1; wb_rd = 7; wb_data = 32'h55;
    #1;
    chk("ldu_retry_ready", in_ready, 1);
    tick();
    chk("ldu_retry_valid", out_valid, 1);
    chk("ldu_retry_a", a, 32'h55);
    chk("ldu_no_extra_stall", stall_count, s0 + 16'd1);

    // Back-to-back issue, no bubbles
    idle();
    for (int k = 0; k < 4; k++) begin
      drive_instr(5'(k + 1), 32'h100 + 32'(k), 3'b001, 5'(k + 2));
      #1;
      chk($sformatf("b2b%0d_ready", k), in_ready, 1);
      tick();
      chk($sformatf("b2b%0d_valid", k), out_valid, 1);
      chk($sformatf("b2b%0d_a", k), a, 32'h100 + 32'(k));
    end

    // Downstream stall for 3 cycles, then flush
    idle();
    drive_instr(5'd12, 32'hCAFE, 3'b101, 5'd9);
    tick();
    sa = a; sb = b;
    chk("dst_first_a", sa, 32'hCAFE);
    drive_instr(5'd13, 32'hBAD0, 3'b110, 5'd3);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("dst%0d_in_ready", k), in_ready, 0);
      tick();
      chk($sformatf("dst%0d_valid", k), out_valid, 1);
      chk($sformatf("dst%0d_a", k), a, 32'hCAFE);
      chk($sformatf("dst%0d_op", k), op, 3'b101);
      chk($sformatf("dst%0d_rd", k), out_rd, 5'd9);
    end
    in_flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_a_hold", a, 32'hCAFE);
    in_flush = 0; in_valid = 0; out_ready = 1;
    tick();
    chk("flush_dropped", out_valid, 0);

    // Reset asserted mid-transfer
    drive_instr(5'd4, 32'h4444, 3'b000, 5'd6);
    out_ready = 0;
    tick();
    chk("mid_pre_valid", out_valid, 1);
    in_valid = 0;
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_a", a, 0);
    chk("mid_rst_rd", out_rd, 0);
    chk("mid_rst_stall", stall_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    reset = 0;
    out_ready = 1;
    tick();
    chk("mid_post_valid", out_valid, 0);

    // Randomised run against the transaction model
    do_reset();
    held.delete();
    m_stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic exp_ready, haz, spc, acc;
      txn_t t;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs      = 5'($urandom_range(0, 7));
      in_rt      = 5'($urandom_range(0, 7));
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_imm     = $urandom;
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_op      = 3'($urandom_range(0, 7));
      in_unsig   = 1'($urandom_range(0, 1));
      in_rd      = 5'($urandom_range(0, 31));
      in_flush   = ($urandom_range(0, 15) == 0);
      ex_wen     = 1'($urandom_range(0, 1));
      ex_rd      = 5'($urandom_range(0, 7));
      ex_data    = $urandom;
      ex_load    = ($urandom_range(0, 2) == 0);
      wb_wen     = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);

      haz = ref_hazard();
      spc = (held.size() == 0) || out_ready;
      exp_ready = in_flush || (spc && !haz);
      acc = in_valid && exp_ready && !in_flush;
      t.a = ref_operand(in_rs, in_rs_data);
      t.b = in_use_imm ? in_imm : ref_operand(in_rt, in_rt_data);
      t.op = in_op; t.unsig = in_unsig; t.rd = in_rd;
      t.ill = (in_op == 3'b011) || (in_op == 3'b111);

      #1;
      chk("rnd_in_ready", in_ready, exp_ready);

      if (in_flush) held.delete();
      else if (acc) begin
        held.delete();
        held.push_back(t);
      end else if (held.size() > 0 && out_ready) held.delete();
      if (haz && spc && !in_flush && m_stall < 65535) m_stall++;

      tick();
      chk("rnd_out_valid", out_valid, held.size() == 1);
      if (held.size() == 1) begin
        chk("rnd_a", a, held[0].a);
        chk("rnd_b", b, held[0].b);
        chk("rnd_op", op, held[0].op);
        chk("rnd_unsig", unsig, held[0].unsig);
        chk("rnd_rd", out_rd, held[0].rd);
        chk("rnd_illegal", out_illegal, held[0].ill);
      end
      chk("rnd_stall_count", stall_count, 16'(m_stall));
    end

    // Stall counter saturation
    do_reset();
    drive_instr(5'd7, 32'h0, 3'b111, 5'd1);
    ex_wen = 1; ex_load = 1; ex_rd = 7;
    for (int k = 0; k < 65534; k++) tick();
    chk("sat_65534", stall_count, 16'hFFFE);
    tick();
    chk("sat_65535", stall_count, 16'hFFFF);
    tick();
    tick();
    chk("sat_hold", stall_count, 16'hFFFF);
    ex_load = 0; ex_wen = 0;
    #1;
    chk("sat_release_ready", in_ready, 1);
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_op_pass", op, 3'b111);
    chk("sat_after", stall_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
